chamber_pressure_ctrl: RTL and testbench
========================================

# chamber_pressure_ctrl

Parametrised pressure-transition controller for one airlock chamber, generalising the fixed-delay evacuate-only block: it drives both evacuation and pressurisation with independently configurable durations. It adds a door interlock, a fault state and request rejection. It sits between the airlock top-level FSM (requests, door sensors) and the chamber status outputs consumed by the door controllers.

## Interface
Parameters:
- CNT_W, 8: timer counter width.
- EVAC_CYCLES, 6: clock cycles from evacuation acceptance to `evacuated`. Legal range is 1..2^CNT_W-1.
- PRESS_CYCLES, 6: clock cycles from pressurisation acceptance to `pressurized`. Legal range is 1..2^CNT_W-1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- evac_req  in  1  level request to evacuate. Sampled each edge.
- press_req  in  1  level request to pressurise. Sampled each edge.
- doors_closed  in  1  high when both chamber doors are sealed.
- fault_clr  in  1  clears the FAULT state.
- pressurized  out  1  chamber is at pressure.
- evacuated  out  1  chamber is at vacuum.
- busy  out  1  a transition is in progress.
- fault  out  1  a door opened during a transition.
- req_rejected  out  1  one-cycle pulse when a request is refused.

## Operation
States: PRESSURIZED, EVACUATING, EVACUATED, PRESSURIZING, FAULT.

Reset:
- State goes to PRESSURIZED and the counter to 0.
- Outputs: pressurized=1, evacuated=0, busy=0, fault=0, req_rejected=0.
- Reset mid-transition aborts the transition immediately, with no partial status.

Transitions:
- PRESSURIZED + evac_req + doors_closed → EVACUATING. Counter loads EVAC_CYCLES-1; pressurized=0, busy=1.
- EVACUATED + press_req + doors_closed → PRESSURIZING. Counter loads PRESS_CYCLES-1; evacuated=0, busy=1.
- EVACUATING/PRESSURIZING:
  - Counter decrements each edge.
  - On the edge where the counter is 0, move to EVACUATED (evacuated=1) or PRESSURIZED (pressurized=1), and busy=0.
- Any transition state with doors_closed=0 → FAULT. Outputs: fault=1, busy=0, pressurized=0, evacuated=0. The door check has priority over counter expiry on the same edge.
- FAULT + fault_clr + doors_closed → PRESSURIZING, loaded with PRESS_CYCLES-1; fault=0. FAULT always recovers by pressurising, never to vacuum.

Requests and rejection:
- A request in the matching stable state while doors_closed=0 is ignored and pulses req_rejected for one cycle.
- A request already satisfied (press_req in PRESSURIZED, evac_req in EVACUATED) is a silent no-op.
- Requests during transitions or FAULT are ignored.
- evac_req and press_req high together: only the request valid for the current stable state acts.

Output invariant: pressurized and evacuated are never both 1. All outputs are registered.

## Timing
- Acceptance happens on edge t. The status output asserts after edge t+EVAC_CYCLES (or t+PRESS_CYCLES), so busy is high for exactly N cycles.
- A level request held through completion does not retrigger, because the new stable state does not accept the same request.
- Back-to-back operation is allowed: an opposite request sampled on the completion edge+1 is accepted.
- req_rejected is high for the single cycle after the refusing edge.
- Fault detection latency is 1 edge after doors_closed falls.

## Configuration
- ABORT_EN defined: an opposite request during a transition (press_req in EVACUATING, evac_req in PRESSURIZING) reverses direction. The controller enters the opposite transition state with the counter reloaded to the full opposite duration, provided doors_closed=1.
- ABORT_EN undefined: opposite requests during transitions are ignored, as for any other request.

## Structure
- Package chamber_pkg holds:
  - the state enum (five states);
  - default duration constants EVAC_CYCLES_DEF=6 and PRESS_CYCLES_DEF=6.
- Sub-module cycle_countdown, parametrised by CNT_W:
  - inputs: load, load_val, en;
  - output: zero.
  - It is reused by both transition states.
- The FSM and output registers stay in chamber_pressure_ctrl.

## Test plan
1. Reset, then evac_req=1 for 1 cycle with doors_closed=1, EVAC_CYCLES=6 → busy high 6 cycles, evacuated=1 at cycle 6, pressurized=0 throughout.
2. From EVACUATED, press_req with PRESS_CYCLES=3 → pressurized=1 exactly 3 cycles after acceptance.
3. evac_req with doors_closed=0 in PRESSURIZED → req_rejected single pulse, state unchanged.
4. doors_closed drops at cycle 2 of evacuation → fault=1 next edge. Then fault_clr with doors closed → pressurising, with pressurized=1 after PRESS_CYCLES.
5. rst asserted mid-evacuation (asynchronous, between edges) → pressurized=1, busy=0 immediately.
6. ABORT_EN defined: press_req at cycle 3 of a 6-cycle evacuation → pressurized=1 PRESS_CYCLES after the abort edge. Without ABORT_EN: evacuated=1 at cycle 6.

Source files
------------

// File: rtl/chamber_pkg.sv
// Shared types and default durations for the airlock chamber pressure controller.
package chamber_pkg;

    // Chamber states. The encoding is fixed so that unused codes (5..7)
    // can be caught by the FSM default branch and steered into FAULT.
    typedef enum logic [2:0] {
        ST_PRESSURIZED  = 3'd0,
        ST_EVACUATING   = 3'd1,
        ST_EVACUATED    = 3'd2,
        ST_PRESSURIZING = 3'd3,
        ST_FAULT        = 3'd4
    } chamber_state_e;

    // Default transition durations in clock cycles.
    localparam int EVAC_CYCLES_DEF  = 6;
    localparam int PRESS_CYCLES_DEF = 6;

    // True for the two states in which the chamber is moving between pressures.
    function automatic logic is_transition(input chamber_state_e st);
        logic res;
        case (st)
            ST_EVACUATING:   res = 1'b1;
            ST_PRESSURIZING: res = 1'b1;
            default:         res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/chamber_pressure_ctrl_cycle_countdown.sv
// Loadable down-counter shared by the evacuation and pressurisation phases.
// 'zero' is decoded from the count register, so it is glitch-free and
// valid from the first cycle after a load.
module cycle_countdown #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_r;

    // Count register: load has priority, decrement saturates at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (load) begin
            cnt_r <= load_val;
        end else if (en && (cnt_r != {CNT_W{1'b0}})) begin
            cnt_r <= cnt_r - CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign zero = (cnt_r == {CNT_W{1'b0}});

endmodule

// File: rtl/chamber_pressure_ctrl.sv
// Airlock chamber pressure-transition controller.
// Drives evacuation and pressurisation with independent durations, trips to
// FAULT if a door opens mid-transition, and pulses req_rejected when a valid
// request arrives while the doors are open.
// Optional build macro ABORT_EN: an opposite request during a transition
// reverses direction with the counter reloaded to the full opposite duration.
module chamber_pressure_ctrl
    import chamber_pkg::*;
#(
    parameter int CNT_W        = 8,
    parameter int EVAC_CYCLES  = EVAC_CYCLES_DEF,
    parameter int PRESS_CYCLES = PRESS_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic evac_req,
    input  logic press_req,
    input  logic doors_closed,
    input  logic fault_clr,
    output logic pressurized,
    output logic evacuated,
    output logic busy,
    output logic fault,
    output logic req_rejected
);

    // The counter holds "edges remaining minus one": a phase of N cycles
    // completes on the edge that sees the counter already at zero.
    localparam logic [CNT_W-1:0] EVAC_LOAD  = CNT_W'(EVAC_CYCLES - 1);
    localparam logic [CNT_W-1:0] PRESS_LOAD = CNT_W'(PRESS_CYCLES - 1);

    chamber_state_e   state_r;
    chamber_state_e   state_nx_s;
    logic             rejected_nx_s;
    logic             cnt_load_s;
    logic [CNT_W-1:0] cnt_load_val_s;
    logic             cnt_en_s;
    logic             cnt_zero_s;

    logic             pressurized_r;
    logic             evacuated_r;
    logic             busy_r;
    logic             fault_r;
    logic             req_rejected_r;

    cycle_countdown #(
        .CNT_W    (CNT_W)
    ) u_countdown (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load_s),
        .load_val (cnt_load_val_s),
        .en       (cnt_en_s),
        .zero     (cnt_zero_s)
    );

    // Next-state, counter control and rejection decode.
    always_comb begin
        state_nx_s     = state_r;
        rejected_nx_s  = 1'b0;
        cnt_load_s     = 1'b0;
        cnt_load_val_s = {CNT_W{1'b0}};
        cnt_en_s       = 1'b0;

        case (state_r)
            ST_PRESSURIZED: begin
                // press_req here is already satisfied and silently ignored.
                if (evac_req) begin
                    if (doors_closed) begin
                        state_nx_s     = ST_EVACUATING;
                        cnt_load_s     = 1'b1;
                        cnt_load_val_s = EVAC_LOAD;
                    end else begin
                        rejected_nx_s  = 1'b1;
                    end
                end else begin
                    state_nx_s = ST_PRESSURIZED;
                end
            end

            ST_EVACUATED: begin
                // evac_req here is already satisfied and silently ignored.
                if (press_req) begin
                    if (doors_closed) begin
                        state_nx_s     = ST_PRESSURIZING;
                        cnt_load_s     = 1'b1;
                        cnt_load_val_s = PRESS_LOAD;
                    end else begin
                        rejected_nx_s  = 1'b1;
                    end
                end else begin
                    state_nx_s = ST_EVACUATED;
                end
            end

            ST_EVACUATING: begin
                // An open door outranks both abort and completion.
                if (!doors_closed) begin
                    state_nx_s = ST_FAULT;
`ifdef ABORT_EN
                end else if (press_req) begin
                    state_nx_s     = ST_PRESSURIZING;
                    cnt_load_s     = 1'b1;
                    cnt_load_val_s = PRESS_LOAD;
`endif
                end else if (cnt_zero_s) begin
                    state_nx_s = ST_EVACUATED;
                end else begin
                    cnt_en_s   = 1'b1;
                end
            end

            ST_PRESSURIZING: begin
                if (!doors_closed) begin
                    state_nx_s = ST_FAULT;
`ifdef ABORT_EN
                end else if (evac_req) begin
                    state_nx_s     = ST_EVACUATING;
                    cnt_load_s     = 1'b1;
                    cnt_load_val_s = EVAC_LOAD;
`endif
                end else if (cnt_zero_s) begin
                    state_nx_s = ST_PRESSURIZED;
                end else begin
                    cnt_en_s   = 1'b1;
                end
            end

            ST_FAULT: begin
                // Recovery always re-pressurises; the chamber state is unknown.
                if (fault_clr && doors_closed) begin
                    state_nx_s     = ST_PRESSURIZING;
                    cnt_load_s     = 1'b1;
                    cnt_load_val_s = PRESS_LOAD;
                end else begin
                    state_nx_s = ST_FAULT;
                end
            end

            default: begin
                // Corrupted state code: fail safe.
                state_nx_s = ST_FAULT;
            end
        endcase
    end

    // State and registered status outputs, decoded from the next state so
    // the status changes on the same edge as the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r        <= ST_PRESSURIZED;
            pressurized_r  <= 1'b1;
            evacuated_r    <= 1'b0;
            busy_r         <= 1'b0;
            fault_r        <= 1'b0;
            req_rejected_r <= 1'b0;
        end else begin
            state_r        <= state_nx_s;
            pressurized_r  <= (state_nx_s == ST_PRESSURIZED);
            evacuated_r    <= (state_nx_s == ST_EVACUATED);
            busy_r         <= is_transition(state_nx_s);
            fault_r        <= (state_nx_s == ST_FAULT);
            req_rejected_r <= rejected_nx_s;
        end
    end

    assign pressurized  = pressurized_r;
    assign evacuated    = evacuated_r;
    assign busy         = busy_r;
    assign fault        = fault_r;
    assign req_rejected = req_rejected_r;

endmodule

// File: tb/tb_chamber_pressure_ctrl.sv
// Self-checking bench for chamber_pressure_ctrl: directed scenarios followed
// by randomized traffic, compared each cycle against a time-remaining model.
module tb_chamber_pressure_ctrl;

    localparam int CNT_W   = 8;
    localparam int EVAC_N  = 6;
    localparam int PRESS_N = 3;
`ifdef ABORT_EN
    localparam bit ABORT = 1'b1;
`else
    localparam bit ABORT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic evac_req;
    logic press_req;
    logic doors_closed;
    logic fault_clr;
    logic pressurized;
    logic evacuated;
    logic busy;
    logic fault;
    logic req_rejected;

    int tests = 0;
    int fails = 0;

    // Reference model: where the chamber last settled, whether it is moving
    // and toward which pressure, and how many busy cycles remain.
    bit m_at_press;
    bit m_to_press;
    bit m_fault;
    bit m_rej;
    int m_left;

    chamber_pressure_ctrl #(
        .CNT_W        (CNT_W),
        .EVAC_CYCLES  (EVAC_N),
        .PRESS_CYCLES (PRESS_N)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .evac_req     (evac_req),
        .press_req    (press_req),
        .doors_closed (doors_closed),
        .fault_clr    (fault_clr),
        .pressurized  (pressurized),
        .evacuated    (evacuated),
        .busy         (busy),
        .fault        (fault),
        .req_rejected (req_rejected)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_at_press = 1'b1;
        m_to_press = 1'b1;
        m_fault    = 1'b0;
        m_rej      = 1'b0;
        m_left     = 0;
    endtask

    task automatic model_step(input bit e, input bit p, input bit d, input bit c);
        m_rej = 1'b0;
        if (m_left > 0) begin
            if (!d) begin
                m_fault = 1'b1;
                m_left  = 0;
            end else if (ABORT && ((m_to_press && e) || (!m_to_press && p))) begin
                m_to_press = !m_to_press;
                m_left     = m_to_press ? PRESS_N : EVAC_N;
            end else begin
                m_left = m_left - 1;
                if (m_left == 0) m_at_press = m_to_press;
            end
        end else if (m_fault) begin
            if (c && d) begin
                m_fault    = 1'b0;
                m_to_press = 1'b1;
                m_left     = PRESS_N;
            end
        end else if (m_at_press) begin
            if (e) begin
                if (d) begin
                    m_to_press = 1'b0;
                    m_left     = EVAC_N;
                end else begin
                    m_rej = 1'b1;
                end
            end
        end else begin
            if (p) begin
                if (d) begin
                    m_to_press = 1'b1;
                    m_left     = PRESS_N;
                end else begin
                    m_rej = 1'b1;
                end
            end
        end
    endtask

    function automatic logic [4:0] model_out();
        logic settled;
        settled = !m_fault && (m_left == 0);
        return {settled && m_at_press, settled && !m_at_press,
                (m_left > 0), m_fault, m_rej};
    endfunction

    task automatic check(input string tag);
        logic [4:0] got;
        logic [4:0] exp;
        got = {pressurized, evacuated, busy, fault, req_rejected};
        exp = model_out();
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: {press,evac,busy,fault,rej} got %b expected %b", tag, got, exp);
        end
    endtask

    // Drive inputs, take one edge, advance the model and compare 1 unit later.
    task automatic step(input bit e, input bit p, input bit d, input bit c, input string tag);
        evac_req     = e;
        press_req    = p;
        doors_closed = d;
        fault_clr    = c;
        @(posedge clk);
        if (rst) model_reset();
        else     model_step(e, p, d, c);
        #1;
        check(tag);
    endtask

    initial begin
        int nbusy;
        int ncyc;
        bit e;
        bit p;
        bit d;
        bit c;

        rst = 1'b1; evac_req = 1'b0; press_req = 1'b0; doors_closed = 1'b1; fault_clr = 1'b0;
        model_reset();
        #1;
        check("reset_async");
        step(1'b1, 1'b1, 1'b1, 1'b1, "reset_hold");
        #3;
        rst = 1'b0;
        step(1'b0, 1'b1, 1'b1, 1'b0, "press_noop");

        // Evacuation: busy for exactly EVAC_N cycles, then evacuated.
        step(1'b1, 1'b0, 1'b1, 1'b0, "evac_accept");
        nbusy = busy ? 1 : 0;
        for (int i = 0; i < 20 && !evacuated; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0, "evac_run");
            if (busy) nbusy++;
        end
        tests++;
        assert (nbusy == EVAC_N && evacuated === 1'b1) else begin
            fails++;
            $error("FAIL evac_len: busy cycles %0d evacuated %b expected %0d and 1", nbusy, evacuated, EVAC_N);
        end
        step(1'b1, 1'b0, 1'b1, 1'b0, "evac_noop");

        // Pressurisation: pressurized exactly PRESS_N cycles after acceptance.
        step(1'b0, 1'b1, 1'b1, 1'b0, "press_accept");
        ncyc = 0;
        for (int i = 0; i < 20 && !pressurized; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0, "press_run");
            ncyc++;
        end
        tests++;
        assert (ncyc == PRESS_N && pressurized === 1'b1) else begin
            fails++;
            $error("FAIL press_len: cycles %0d pressurized %b expected %0d and 1", ncyc, pressurized, PRESS_N);
        end

        // Rejection with doors open: one-cycle pulse, state unchanged.
        step(1'b1, 1'b0, 1'b0, 1'b0, "reject_pulse");
        tests++;
        assert (req_rejected === 1'b1 && pressurized === 1'b1) else begin
            fails++;
            $error("FAIL reject_lit: rej %b press %b expected 1 1", req_rejected, pressurized);
        end
        step(1'b0, 1'b0, 1'b1, 1'b0, "reject_clear");

        // Door opens during evacuation -> fault, then recover by pressurising.
        step(1'b1, 1'b0, 1'b1, 1'b0, "fault_evac_start");
        step(1'b0, 1'b0, 1'b1, 1'b0, "fault_evac_c1");
        step(1'b0, 1'b0, 1'b0, 1'b0, "fault_trip");
        tests++;
        assert (fault === 1'b1 && busy === 1'b0 && pressurized === 1'b0 && evacuated === 1'b0) else begin
            fails++;
            $error("FAIL fault_lit: fault %b busy %b press %b evac %b expected 1 0 0 0", fault, busy, pressurized, evacuated);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1, "fault_clr_doors_open");
        step(1'b1, 1'b0, 1'b1, 1'b0, "fault_ignore_req");
        step(1'b0, 1'b0, 1'b1, 1'b1, "fault_recover");
        for (int i = 0; i < PRESS_N + 1; i++) step(1'b0, 1'b0, 1'b1, 1'b0, "fault_repress");

        // Asynchronous reset between edges mid-evacuation.
        step(1'b1, 1'b0, 1'b1, 1'b0, "arst_evac_start");
        step(1'b0, 1'b0, 1'b1, 1'b0, "arst_evac_c1");
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        check("arst_immediate");
        tests++;
        assert (pressurized === 1'b1 && busy === 1'b0) else begin
            fails++;
            $error("FAIL arst_lit: press %b busy %b expected 1 0", pressurized, busy);
        end
        step(1'b0, 1'b0, 1'b1, 1'b0, "arst_hold");
        #2;
        rst = 1'b0;

        // Opposite request at cycle 3 of an evacuation (reverses only with ABORT_EN).
        step(1'b1, 1'b0, 1'b1, 1'b0, "abort_start");
        step(1'b0, 1'b0, 1'b1, 1'b0, "abort_c1");
        step(1'b0, 1'b0, 1'b1, 1'b0, "abort_c2");
        step(1'b0, 1'b1, 1'b1, 1'b0, "abort_req");
        for (int i = 0; i < EVAC_N + PRESS_N; i++) step(1'b0, 1'b0, 1'b1, 1'b0, "abort_run");

        // Level request held through completion, opposite request right after.
        if (!pressurized) begin
            for (int i = 0; i < EVAC_N + PRESS_N && !(pressurized || evacuated); i++)
                step(1'b0, 1'b0, 1'b1, 1'b0, "settle");
        end
        for (int i = 0; i < EVAC_N + 2; i++) step(1'b1, 1'b0, 1'b1, 1'b0, "level_hold");
        for (int i = 0; i < PRESS_N + 2; i++) step(1'b1, 1'b1, 1'b1, 1'b0, "both_reqs");

        // Randomized traffic with mostly-closed doors.
        for (int i = 0; i < 600; i++) begin
            e = ($urandom_range(0, 9) < 3);
            p = ($urandom_range(0, 9) < 3);
            d = ($urandom_range(0, 15) != 0);
            c = ($urandom_range(0, 9) < 2);
            step(e, p, d, c, "random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
